aes_inv_cipher_iter: RTL

Iterative AES inverse cipher that decrypts one 128-bit block using the standard (non-equivalent) inverse cipher ordering. It completes one inverse round per clock and reads round keys from an external key-schedule store through an index/data port. It uses the same unmodified encryption key schedule as the forward round datapath. Valid/ready handshakes on both input and output let it sit between a ciphertext source and a plaintext sink.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_inv_round.sv | 41 ++++
 rtl/aes_inv_cipher_iter.sv | 106 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
//   - aes_fsm_e : control FSM encoding
//   - INV_SBOX  : 256-entry inverse substitution table
//   - xtime / gmul9 / gmul11 / gmul13 / gmul14 : GF(2^8) constant multipliers
//   - byte_off  : bit offset of (row, col) in a [0:127] block.
//                 Byte k = 4*col + row occupies bits [8k : 8k+7], so the
//                 first byte on the wire is row 0 of column 0.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic int byte_off(input int row, input int col);
    return 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
//   state_i : block entering the round ([0:127], column-major bytes)
//   rk_i    : round key to add
//   final_i : 1 = last round, InvMixColumns is skipped
//   state_o : InvMixColumns(InvSubBytes(InvShiftRows(state_i)) ^ rk_i),
//             or without InvMixColumns when final_i is set
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rk_i,
  input  logic         final_i,
  output logic [0:127] state_o
);

  logic [0:127] sb;
  logic [0:127] ark;
  logic [0:127] mix;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // InvShiftRows rotates row r right by r: out(r, c) = in(r, c - r).
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sb[byte_off(r, c) +: 8] = INV_SBOX[state_i[byte_off(r, (c - r + 4) % 4) +: 8]];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[byte_off(0, c) +: 8];
    assign a1 = ark[byte_off(1, c) +: 8];
    assign a2 = ark[byte_off(2, c) +: 8];
    assign a3 = ark[byte_off(3, c) +: 8];

    assign mix[byte_off(0, c) +: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign mix[byte_off(1, c) +: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign mix[byte_off(2, c) +: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign mix[byte_off(3, c) +: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
  end

  assign ark     = sb ^ rk_i;
  assign state_o = final_i ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one inverse round per clock.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : ciphertext handshake, ciphertext sampled on accept
//   rk_idx/rk         : round-key index out, key returned in the same cycle
//   out_valid/out_ready, plaintext : result handshake, plaintext held in DONE
//   busy              : high whenever the FSM is not IDLE
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high; valid is never withdrawn by this block
// before the transfer, and ready is asserted only in IDLE (input) so input
// and output never overlap.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] plaintext,
  output logic         busy
);

  if (Nr != Nk + 6) begin : g_bad_nr
    $fatal(1, "aes_inv_cipher_iter: Nr must equal Nk+6");
  end

  localparam logic [3:0] NR_IDX = 4'(Nr);
  localparam logic [3:0] NR_M1  = 4'(Nr - 1);

  aes_fsm_e     fsm_q, fsm_d;
  logic [0:127] data_q, data_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [0:127] round_out;

  aes_inv_round u_round (
    .state_i (data_q),
    .rk_i    (rk),
    .final_i (fsm_q == ST_FINAL),
    .state_o (round_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      data_q <= '0;
      rnd_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      rnd_q  <= rnd_d;
    end
  end

  // Next state
  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    rnd_d  = rnd_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d = ciphertext ^ rk;   // initial AddRoundKey with w[Nr]
          rnd_d  = NR_M1;
          fsm_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d = round_out;
        if (rnd_q == 4'd1) fsm_d = ST_FINAL;
        else               rnd_d = rnd_q - 4'd1;
      end
      ST_FINAL: begin
        data_d = round_out;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (fsm_q == ST_IDLE) && !rst;
    out_valid = (fsm_q == ST_DONE);
    busy      = (fsm_q != ST_IDLE);
    case (fsm_q)
      ST_IDLE:  rk_idx = NR_IDX;
      ST_ROUND: rk_idx = rnd_q;
      default:  rk_idx = 4'd0;
    endcase
  end

  assign plaintext = data_q;

endmodule
